// File: rtl/ndro_pkg.sv
// ndro_pkg: shared definitions for the NDRO cell checker.
//   ndro_state_e : checker FSM states (IDLE, EXPECT, GUARD)
//   ERR_*        : err_code values, ordered by priority (OVERLAP highest)
package ndro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPECT = 2'd1,
        ST_GUARD  = 2'd2
    } ndro_state_e;

    localparam logic [1:0] ERR_MISSING  = 2'd0;
    localparam logic [1:0] ERR_SPURIOUS = 2'd1;
    localparam logic [1:0] ERR_CONFLICT = 2'd2;
    localparam logic [1:0] ERR_OVERLAP  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset, clears the count
//   i_inc   : add one on this edge (ignored once saturated)
//   o_count : current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/basic_ndro_checker.sv
// basic_ndro_checker: protocol checker for a non-destructive readout cell.
// Tracks the cell's stored bit from set/reset pulses and, after every
// readout clock, opens a window of WINDOW cycles in which an output pulse
// must (stored=1) or must not (stored=0) appear.
//   clk, rst            : clock, asynchronous active-high reset
//   ndro_set/ndro_reset : cell set / reset pulses
//   ndro_clk            : cell readout clock pulse
//   ndro_out            : cell output pulse
//   stored              : modelled cell state
//   busy                : readout window open
//   err, err_code       : one-cycle error strobe and its cause
//   read_cnt, err_cnt   : saturating readout and error counters
module basic_ndro_checker
    import ndro_pkg::*;
#(
    parameter int unsigned WINDOW = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ndro_set,
    input  logic             ndro_reset,
    input  logic             ndro_clk,
    input  logic             ndro_out,
    output logic             stored,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] read_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned WIN_W = $clog2(WINDOW + 1);

    ndro_state_e      r_state;
    logic             r_stored;
    logic             r_busy;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [WIN_W-1:0] r_win;

    logic             w_conflict;
    logic             w_overlap;
    logic             w_spurious;
    logic             w_missing;
    logic             w_win_last;
    logic             w_any_err;
    logic [1:0]       w_code;

    always_comb begin
        w_conflict = ndro_set & ndro_reset;
        w_overlap  = ndro_clk & (r_state != ST_IDLE);
        w_win_last = (r_win == WIN_W'(WINDOW));
        // Output is unexpected anywhere except inside an EXPECT window;
        // this covers IDLE (even alongside a fresh ndro_clk) and GUARD.
        w_spurious = ndro_out & (r_state != ST_EXPECT);
        // A re-read abandons the window, so no missing check on that edge.
        w_missing  = (r_state == ST_EXPECT) & w_win_last & ~ndro_out & ~ndro_clk;
        w_any_err  = w_overlap | w_conflict | w_spurious | w_missing;

        w_code = ERR_MISSING;
        if (w_overlap) begin
            w_code = ERR_OVERLAP;
        end else if (w_conflict) begin
            w_code = ERR_CONFLICT;
        end else if (w_spurious) begin
            w_code = ERR_SPURIOUS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_stored   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_MISSING;
            r_win      <= '0;
        end else begin
            r_err      <= w_any_err;
            r_err_code <= w_any_err ? w_code : ERR_MISSING;

            if (!w_conflict) begin
                if (ndro_set) begin
                    r_stored <= 1'b1;
                end else if (ndro_reset) begin
                    r_stored <= 1'b0;
                end
            end

            // A readout clock always (re)starts a window; the expectation is
            // the stored bit before this edge's set/reset takes effect.
            if (ndro_clk) begin
                r_state <= r_stored ? ST_EXPECT : ST_GUARD;
                r_busy  <= 1'b1;
                r_win   <= WIN_W'(1);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    ST_EXPECT, ST_GUARD: begin
                        if (ndro_out || w_win_last) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_win   <= '0;
                        end else begin
                            r_win <= r_win + WIN_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_win   <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_read_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (ndro_clk),
        .o_count (read_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (w_any_err),
        .o_count (err_cnt)
    );

    assign stored   = r_stored;
    assign busy     = r_busy;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_basic_ndro_checker.sv
module tb_basic_ndro_checker;

    localparam int WINDOW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ndro_set = 1'b0, ndro_reset = 1'b0, ndro_clk = 1'b0, ndro_out = 1'b0;

    logic        stored, busy, err;
    logic [1:0]  err_code;
    logic [15:0] read_cnt, err_cnt;

    logic        stored2, busy2, err2;
    logic [1:0]  err_code2;
    logic [1:0]  read_cnt2, err_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    basic_ndro_checker #(.WINDOW(WINDOW), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .ndro_set(ndro_set), .ndro_reset(ndro_reset),
        .ndro_clk(ndro_clk), .ndro_out(ndro_out), .stored(stored), .busy(busy),
        .err(err), .err_code(err_code), .read_cnt(read_cnt), .err_cnt(err_cnt)
    );

    basic_ndro_checker #(.WINDOW(WINDOW), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .ndro_set(ndro_set), .ndro_reset(ndro_reset),
        .ndro_clk(ndro_clk), .ndro_out(ndro_out), .stored(stored2), .busy(busy2),
        .err(err2), .err_code(err_code2), .read_cnt(read_cnt2), .err_cnt(err_cnt2)
    );

    // Behavioural model: window tracked by the edge number that opened it.
    int t = 0;
    bit m_stored = 0, m_open = 0, m_exp = 0, m_err = 0;
    int m_t0 = 0, m_code = 0, m_reads = 0, m_errs = 0;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stored = 0; m_open = 0; m_exp = 0; m_err = 0;
        m_code = 0; m_reads = 0; m_errs = 0;
    endtask

    task automatic model_edge();
        bit pre;
        bit [3:0] hit;
        pre = m_stored;
        hit = '0;
        t++;
        if (ndro_set && ndro_reset) hit[2] = 1'b1;
        else if (ndro_set)          m_stored = 1;
        else if (ndro_reset)        m_stored = 0;
        if (m_open && ndro_clk) begin
            hit[3] = 1'b1;
        end else if (m_open) begin
            if (ndro_out) begin
                if (!m_exp) hit[1] = 1'b1;
                m_open = 0;
            end else if (t - m_t0 == WINDOW) begin
                if (m_exp) hit[0] = 1'b1;
                m_open = 0;
            end
        end else if (ndro_out) begin
            hit[1] = 1'b1;
        end
        if (ndro_clk) begin
            m_open = 1; m_exp = pre; m_t0 = t; m_reads++;
        end
        m_err  = |hit;
        m_code = hit[3] ? 3 : hit[2] ? 2 : hit[1] ? 1 : 0;
        if (m_err) m_errs++;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("stored",    int'(stored),    int'(m_stored));
        chk("busy",      int'(busy),      int'(m_open));
        chk("err",       int'(err),       int'(m_err));
        if (m_err) chk("err_code", int'(err_code), m_code);
        chk("read_cnt",  int'(read_cnt),  sat(m_reads, 16));
        chk("err_cnt",   int'(err_cnt),   sat(m_errs, 16));
        chk("stored2",   int'(stored2),   int'(m_stored));
        chk("busy2",     int'(busy2),     int'(m_open));
        chk("err2",      int'(err2),      int'(m_err));
        if (m_err) chk("err_code2", int'(err_code2), m_code);
        chk("read_cnt2", int'(read_cnt2), sat(m_reads, 2));
        chk("err_cnt2",  int'(err_cnt2),  sat(m_errs, 2));
    end

    // One clock cycle: apply inputs, step the model on the edge, settle.
    task automatic drive(input bit s, input bit r, input bit c, input bit o);
        ndro_set = s; ndro_reset = r; ndro_clk = c; ndro_out = o;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stored"},   int'(stored),   0);
        chk({tag, "_busy"},     int'(busy),     0);
        chk({tag, "_err"},      int'(err),      0);
        chk({tag, "_err_code"}, int'(err_code), 0);
        chk({tag, "_read_cnt"}, int'(read_cnt), 0);
        chk({tag, "_err_cnt"},  int'(err_cnt),  0);
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        model_reset();
        #1 chk_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_sat[5] = '{1, 2, 3, 3, 3};

    initial begin
        model_reset();
        #1 chk_all_zero("rst_init");
        @(negedge clk);
        rst = 1'b0;

        // set, read, answer in window cycle 2
        idle(1);
        drive(1, 0, 0, 0);  chk("set_stored", int'(stored), 1);
        idle(2);
        drive(0, 0, 1, 0);  chk("read_busy", int'(busy), 1);
        idle(1);
        drive(0, 0, 0, 1);
        chk("ok_busy", int'(busy), 0);
        chk("ok_err", int'(err), 0);
        chk("ok_reads", int'(read_cnt), 1);

        // missing output: error at close of window cycle WINDOW
        drive(0, 0, 1, 0);
        idle(WINDOW - 1);
        chk("miss_pre_err", int'(err), 0);
        chk("miss_pre_busy", int'(busy), 1);
        idle(1);
        chk("miss_err", int'(err), 1);
        chk("miss_code", int'(err_code), 0);
        chk("miss_cnt", int'(err_cnt), 1);
        chk("miss_busy", int'(busy), 0);
        idle(1);
        chk("miss_strobe_1cyc", int'(err), 0);

        // output in the last window cycle is still on time
        drive(0, 0, 1, 0);
        idle(WINDOW - 1);
        drive(0, 0, 0, 1);
        chk("late_ok_err", int'(err), 0);

        // spurious outputs in GUARD and IDLE
        async_reset();
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 1);
        chk("guard_err", int'(err), 1);
        chk("guard_code", int'(err_code), 1);
        idle(2);
        drive(0, 0, 0, 1);
        chk("idle_out_code", int'(err_code), 1);
        chk("idle_out_cnt", int'(err_cnt), 2);

        // conflict, then set with read: expectation is the old stored=0
        drive(1, 1, 0, 0);
        chk("conf_stored", int'(stored), 0);
        chk("conf_code", int'(err_code), 2);
        drive(1, 0, 1, 0);
        chk("setclk_stored", int'(stored), 1);
        drive(0, 0, 0, 1);
        chk("setclk_code", int'(err_code), 1);
        chk("setclk_cnt", int'(err_cnt), 4);

        // reset inside window keeps expectation 1
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);  chk("win_rst_stored", int'(stored), 0);
        drive(0, 0, 0, 1);  chk("win_rst_err", int'(err), 0);
        // GUARD closes quietly even though stored is set inside it
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        idle(WINDOW - 1);
        chk("quiet_busy", int'(busy), 0);
        chk("quiet_err", int'(err), 0);
        // output together with read in IDLE
        drive(0, 0, 1, 1);
        chk("clkout_code", int'(err_code), 1);
        chk("clkout_busy", int'(busy), 1);
        drive(0, 0, 0, 1);
        chk("clkout_close", int'(err), 0);

        // missing and conflict together: conflict wins, one count
        drive(0, 0, 1, 0);
        idle(WINDOW - 1);
        drive(1, 1, 0, 0);
        chk("prio_code", int'(err_code), 2);
        chk("prio_cnt", int'(err_cnt), 6);

        // overlapping reads, then reset with window open
        drive(0, 0, 1, 0);
        idle(1);
        drive(0, 0, 1, 0);
        chk("ovl_code", int'(err_code), 3);
        chk("ovl_busy", int'(busy), 1);
        drive(1, 1, 1, 0);
        chk("ovl_conf_code", int'(err_code), 3);
        async_reset();
        idle(WINDOW + 1);

        // first edge after reset is processed
        drive(1, 0, 0, 0);
        chk("post_rst_set", int'(stored), 1);

        // narrow counters saturate
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1);
            chk("sat_err_cnt2", int'(err_cnt2), exp_sat[i]);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0);
            drive(0, 0, 0, 1);
        end
        chk("sat_read_cnt2", int'(read_cnt2), 3);
        idle(2);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/basic_ndro_checker.md
BASIC_NDRO_CHECKER -- requirements
Module: basic_ndro_checker

Interface
REQ-001 Parameter: WINDOW, default 4, the maximum number of clk cycles (1..WINDOW) after an ndro_clk pulse within which ndro_out may arrive.
REQ-002 Parameter: CNT_W, default 16, the width of the read and error counters.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ndro_set  input  1  single-cycle pulse; the cell's set input fired.
REQ-006 ndro_reset  input  1  single-cycle pulse; the cell's reset input fired.
REQ-007 ndro_clk  input  1  single-cycle pulse; the cell's readout clock fired.
REQ-008 ndro_out  input  1  single-cycle pulse; the cell's output fired.
REQ-009 stored  output  1  model state bit of the cell, where 1 means set.
REQ-010 busy  output  1  a readout window is open.
REQ-011 err  output  1  one-cycle error strobe.
REQ-012 err_code  output  2  error cause, valid only while err=1: 0 missing, 1 spurious, 2 set/reset conflict, 3 overlapping read.
REQ-013 read_cnt  output  CNT_W  count of ndro_clk pulses accepted.
REQ-014 err_cnt  output  CNT_W  count of err strobes.

Function
REQ-015 The stored bit shall be set by ndro_set, cleared by ndro_reset, and left unchanged by ndro_clk (the read is non-destructive).
REQ-016 If ndro_set and ndro_reset occur in the same cycle, stored shall be unchanged and err shall be raised with code 2.
REQ-017 The FSM states shall be IDLE, EXPECT and GUARD.
- IDLE with ndro_clk: go to EXPECT if stored=1, otherwise go to GUARD.
- The expectation shall be latched from stored as it was before that edge.
REQ-018 In EXPECT or GUARD, a window counter shall load 1 on entry and increment each cycle; the window closes after cycle WINDOW.
REQ-019 EXPECT rules:
- ndro_out in window cycles 1..WINDOW: go to IDLE, no error.
- Window closes without ndro_out: err with code 0, then go to IDLE.
REQ-020 GUARD rules:
- ndro_out in window: err with code 1, go to IDLE.
- Window closes quietly: go to IDLE, no error.
REQ-021 ndro_out while in IDLE, including in the same cycle as ndro_clk, shall raise err with code 1.
REQ-022 ndro_clk while a window is open shall raise err with code 3 and abandon the current window without a code-0 check. A new window shall then start from the current stored value.
REQ-023 ndro_set or ndro_reset during an open window shall update stored but not the latched expectation.
REQ-024 When more than one error fires in a cycle, err_code shall report the highest priority: 3 > 2 > 1 > 0.
- err_cnt shall increment by 1 only.
REQ-025 read_cnt shall increment on every ndro_clk pulse.
REQ-026 read_cnt and err_cnt shall saturate at all-ones and never wrap.
REQ-027 busy shall be 1 exactly in EXPECT and GUARD.
REQ-028 err shall be registered: it asserts on the edge that detects the error and lasts exactly one cycle.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, stored=0, busy=0, err=0, err_code=0, read_cnt=0, err_cnt=0, window counter=0.
REQ-030 Reset during an open window shall discard the window silently, with no err.
REQ-031 The first edge after rst deasserts shall process its inputs normally.

Structure
REQ-032 A shared package ndro_pkg shall hold the FSM state enumeration and the err_code constants ERR_MISSING, ERR_SPURIOUS, ERR_CONFLICT and ERR_OVERLAP.
REQ-033 A single sub-module sat_counter, parameterised by width, shall implement both counters.
REQ-034 The block shall not instantiate basic_ndro; it is driven only by sampled pulses.

Verification
REQ-035 Scenario: set@c2, clk@c5, out@c7 -> stored=1 from c3, busy c6..c7, no err, read_cnt=1.
REQ-036 Scenario: set, then clk, then no out for 4 cycles -> err=1 with code 0 at the close of window cycle 4, err_cnt=1, state back to IDLE.
REQ-037 Scenario: after reset, clk@c5, out@c6 -> err with code 1 at c6; out@c9 with no clk -> err with code 1, err_cnt=2.
REQ-038 Scenario: set and reset in the same cycle with stored=0 -> stored stays 0, err code 2. Then set and clk in the same cycle -> GUARD, expectation 0.
REQ-039 Scenario: clk@c5, then clk@c7 -> err code 3 at c7, window restarts, read_cnt=2. rst asserted at c8 -> all outputs 0 immediately.
REQ-040 Scenario: CNT_W=2, five spurious outs -> err_cnt reads 1,2,3,3,3.
